// File: rtl/trap_vector_sequencer.sv
// trap_vector_sequencer
//
// Multi-cycle controller for the LC-3 TRAP instruction. It takes the
// zero-extended trapvect8 from the extend stage and runs four steps:
//   1. Save the return PC into the link register (R7 by default).
//   2. Read the vector table entry at the trap address.
//   3. Load the PC with the service-routine address that was fetched.
//   4. Return to idle.
//
// Optional feature (macro TRAP_SEQ_TIMEOUT_EN):
//   Adds a memory-wait watchdog and an ERR state that pulses err instead
//   of loading the PC. Without the macro, MEM waits forever and err is 0.
//
// Ports:
//   clk, rst      - system clock, asynchronous active-high reset
//   start         - one-cycle trap request (ignored while busy)
//   trap_addr_in  - zero-extended trap vector; only the low VEC_WIDTH bits are used
//   pc_in         - incremented PC, saved as the return address
//   reg_wr_en     - register-file write strobe
//   reg_wr_addr   - register-file write index
//   reg_wr_data   - register-file write data
//   mem_req       - memory read request
//   mem_addr      - memory read address
//   mem_rdata     - memory read data
//   mem_ready     - memory read completion
//   pc_load       - PC load strobe
//   pc_out        - new PC value
//   busy          - sequence in progress
//   done          - one-cycle completion pulse
//   err           - one-cycle timeout pulse
module trap_vector_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int VEC_WIDTH      = 8,
  parameter int LINK_REG       = 7,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] trap_addr_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  reg_wr_en,
  output logic [2:0]            reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  pc_load,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

`ifdef TRAP_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, SAVE, MEM, LOAD, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SAVE, MEM, LOAD} state_t;
`endif

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] vec;
  logic [DATA_WIDTH-1:0] ret_pc;
  logic [DATA_WIDTH-1:0] tgt;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [2:0]            wr_addr_q;
  logic [DATA_WIDTH-1:0] vec_ext;
  logic                  unused_upper_bits;
  logic                  limit_hit;

  // Re-zero-extend the vector here, so that junk in the upper bits of
  // trap_addr_in can never point the table read outside the vector table.
  assign vec_ext           = {{(DATA_WIDTH-VEC_WIDTH){1'b0}}, trap_addr_in[VEC_WIDTH-1:0]};
  assign unused_upper_bits = ^trap_addr_in[DATA_WIDTH-1:VEC_WIDTH];

`ifdef TRAP_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Watchdog on the memory wait. MEM can only be entered from SAVE, so the
  // count is cleared in SAVE. It then counts every MEM cycle in which the
  // memory is not ready. limit_hit marks the cycle whose stall would take
  // the count to TIMEOUT_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == SAVE) begin
      wait_cnt <= '0;
    end else if (state == MEM && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign limit_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign limit_hit = 1'b0;
`endif

  // State register. Reset aborts any sequence in progress, so a pending
  // PC load never happens once rst has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and Moore strobes. mem_ready only matters in MEM, and
  // it beats the watchdog when both arrive in the same cycle.
  always_comb begin
    next_state = state;
    reg_wr_en  = 1'b0;
    mem_req    = 1'b0;
    pc_load    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) next_state = SAVE;
      end
      SAVE: begin
        reg_wr_en  = 1'b1;
        next_state = MEM;
      end
      MEM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          next_state = LOAD;
        end else if (limit_hit) begin
`ifdef TRAP_SEQ_TIMEOUT_EN
          next_state = ERR;
`else
          next_state = MEM;
`endif
        end
      end
      LOAD: begin
        pc_load    = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
`ifdef TRAP_SEQ_TIMEOUT_EN
      ERR: begin
        err        = 1'b1;
        next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. Each output value is loaded on the edge that
  // enters the state where it is used, then held until the next sequence.
  // The write index and the return PC are loaded on the accepting edge so
  // they are valid during SAVE. The read address is loaded on the way into
  // MEM, and the fetched target on the way into LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      ret_pc     <= '0;
      tgt        <= '0;
      mem_addr_q <= '0;
      wr_addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= vec_ext;
            ret_pc    <= pc_in;
            wr_addr_q <= 3'(LINK_REG);
          end
        end
        SAVE: mem_addr_q <= vec;
        MEM:  if (mem_ready) tgt <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = ret_pc;
  assign mem_addr    = mem_addr_q;
  assign pc_out      = tgt;

endmodule

// File: tb/tb_trap_vector_sequencer.sv
// Testbench for trap_vector_sequencer.
// Drives directed and randomized traps and checks every cycle against a
// timeline model built from the sequencer's documented behaviour.
module tb_trap_vector_sequencer;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int LR = 7;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] trap_addr_in = '0;
  logic [DW-1:0] pc_in = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          reg_wr_en, mem_req, pc_load, busy, done, err;
  logic [2:0]    reg_wr_addr;
  logic [DW-1:0] reg_wr_data, mem_addr, pc_out;

  trap_vector_sequencer #(
    .DATA_WIDTH(DW), .VEC_WIDTH(VW), .LINK_REG(LR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .trap_addr_in(trap_addr_in),
    .pc_in(pc_in), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_load(pc_load),
    .pc_out(pc_out), .busy(busy), .done(done), .err(err)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the held output values.
  logic [2:0]    exp_wr_addr = '0;
  logic [DW-1:0] exp_wr_data = '0;
  logic [DW-1:0] exp_mem_addr = '0;
  logic [DW-1:0] exp_pc_out = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Compare every output with the expected strobes and held values.
  task automatic checkCycle(input string ph, input bit wr, input bit req, input bit ld,
                            input bit dn, input bit er, input bit bsy);
    checkOutput({ph, "/reg_wr_en"},   32'(reg_wr_en),   32'(wr));
    checkOutput({ph, "/mem_req"},     32'(mem_req),     32'(req));
    checkOutput({ph, "/pc_load"},     32'(pc_load),     32'(ld));
    checkOutput({ph, "/done"},        32'(done),        32'(dn));
    checkOutput({ph, "/err"},         32'(err),         32'(er));
    checkOutput({ph, "/busy"},        32'(busy),        32'(bsy));
    checkOutput({ph, "/reg_wr_addr"}, 32'(reg_wr_addr), 32'(exp_wr_addr));
    checkOutput({ph, "/reg_wr_data"}, 32'(reg_wr_data), 32'(exp_wr_data));
    checkOutput({ph, "/mem_addr"},    32'(mem_addr),    32'(exp_mem_addr));
    checkOutput({ph, "/pc_out"},      32'(pc_out),      32'(exp_pc_out));
  endtask

  // Idle cycles: stray mem_ready must have no effect.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkCycle("idle", 0, 0, 0, 0, 0, 0);
      start        = 1'b0;
      mem_ready    = 1'($urandom_range(0, 1));
      mem_rdata    = 16'($urandom);
      trap_addr_in = 16'($urandom);
    end
  endtask

  // One complete trap. Entered just before the IDLE cycle in which start
  // is driven. While busy, junk start requests with different vectors are
  // driven, and the model expects them to be ignored. wait_n is the number
  // of not-ready MEM cycles before the data arrives. With expect_timeout
  // set, the memory never answers.
  task automatic applyStimulus(input logic [DW-1:0] taddr, input logic [DW-1:0] pc,
                               input logic [DW-1:0] rdata, input int wait_n,
                               input bit expect_timeout);
    logic [DW-1:0] mask;
    int            n_mem;
    mask = (DW'(1) << VW) - DW'(1);
    @(negedge clk);
    checkCycle("idle", 0, 0, 0, 0, 0, 0);
    start        = 1'b1;
    trap_addr_in = taddr;
    pc_in        = pc;
    mem_ready    = 1'($urandom_range(0, 1));
    mem_rdata    = 16'($urandom);

    @(negedge clk);
    exp_wr_addr = 3'(LR);
    exp_wr_data = pc;
    checkCycle("save", 1, 0, 0, 0, 0, 1);
    start        = 1'($urandom_range(0, 1));
    trap_addr_in = 16'($urandom);
    pc_in        = 16'($urandom);
    mem_ready    = 1'($urandom_range(0, 1));
    mem_rdata    = 16'($urandom);

    exp_mem_addr = taddr & mask;
    n_mem = expect_timeout ? TO : wait_n + 1;
    for (int k = 0; k < n_mem; k++) begin
      @(negedge clk);
      checkCycle("mem", 0, 1, 0, 0, 0, 1);
      start        = 1'($urandom_range(0, 1));
      trap_addr_in = 16'($urandom);
      pc_in        = 16'($urandom);
      mem_ready    = (!expect_timeout && k == wait_n);
      mem_rdata    = mem_ready ? rdata : 16'($urandom);
    end

    @(negedge clk);
    if (expect_timeout) begin
      checkCycle("err", 0, 0, 0, 0, 1, 1);
    end else begin
      exp_pc_out = rdata;
      checkCycle("load", 0, 0, 1, 1, 0, 1);
    end
    start        = 1'($urandom_range(0, 1));
    trap_addr_in = 16'($urandom);
    mem_ready    = 1'($urandom_range(0, 1));
  endtask

  // Assert reset asynchronously, away from the clock edge. Everything must
  // clear at once and nothing may follow.
  task automatic resetNow();
    rst = 1'b1;
    #1;
    exp_wr_addr  = '0;
    exp_wr_data  = '0;
    exp_mem_addr = '0;
    exp_pc_out   = '0;
    checkCycle("rst", 0, 0, 0, 0, 0, 0);
    start     = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkCycle("rsthold", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    idleCycles(3);
  endtask

  initial begin
    $display("[TB] trap_vector_sequencer bench start");
    repeat (2) @(negedge clk);
    checkCycle("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic trap, masked vector with wait states, then back-to-back.
    applyStimulus(16'h0025, 16'h3001, 16'h0490, 0, 1'b0);
    idleCycles(1);
    applyStimulus(16'hFF23, 16'h4000, 16'h0520, 3, 1'b0);
    applyStimulus(16'h0021, 16'h4100, 16'h0600, 0, 1'b0);

    // Randomized traps with random gaps (sometimes none).
    for (int t = 0; t < 30; t++) begin
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 6)), 1'b0);
      idleCycles(int'($urandom_range(0, 2)));
    end

`ifdef TRAP_SEQ_TIMEOUT_EN
    // A reply in the limit cycle wins; silence produces a single err pulse.
    applyStimulus(16'h0030, 16'h5000, 16'h0777, TO - 1, 1'b0);
    applyStimulus(16'h0031, 16'h5001, 16'h0000, 0, 1'b1);
    idleCycles(2);
    applyStimulus(16'h0032, 16'h5002, 16'h0888, 1, 1'b0);
`else
    // Without the watchdog, a long wait still completes normally.
    applyStimulus(16'h0030, 16'h5000, 16'h0777, 20, 1'b0);
`endif

    // Reset mid-idle.
    idleCycles(1);
    resetNow();

    // Reset mid-MEM: the memory answers afterwards, but no load may follow.
    @(negedge clk);
    checkCycle("idle", 0, 0, 0, 0, 0, 0);
    start = 1'b1; trap_addr_in = 16'h0044; pc_in = 16'h6000; mem_ready = 1'b0;
    @(negedge clk);
    exp_wr_addr = 3'(LR);
    exp_wr_data = 16'h6000;
    checkCycle("save", 1, 0, 0, 0, 0, 1);
    start = 1'b0;
    @(negedge clk);
    exp_mem_addr = 16'h0044;
    checkCycle("mem", 0, 1, 0, 0, 0, 1);
    resetNow();

    // Normal operation after reset.
    applyStimulus(16'h0025, 16'h3001, 16'h0490, 2, 1'b0);
    idleCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_vector_sequencer.md
Name: trap_vector_sequencer

Overview:
- Multi-cycle controller for the LC-3 TRAP instruction; consumes the 16-bit zero-extended trapvect8 produced by the zero_extender stage (instantiated with width 8).
- Saves the return PC into the link register, reads the vector table entry at the trap address and loads the PC with the fetched service-routine address.
- Sits between the decode/extend datapath and the register file, memory port and PC register.

Parameters:
- DATA_WIDTH, 16, width of PC, addresses and memory data
- VEC_WIDTH, 8, number of significant low bits of trap_addr_in
- LINK_REG, 7, register-file index that receives the return PC
- TIMEOUT_CYCLES, 16, maximum memory-wait cycles; used only with the optional feature

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle trap request from the control unit
- trap_addr_in  in  DATA_WIDTH  zero-extended trap vector
- pc_in  in  DATA_WIDTH  current (already incremented) PC
- reg_wr_en  out  1  register-file write strobe
- reg_wr_addr  out  3  register-file write index
- reg_wr_data  out  DATA_WIDTH  register-file write data
- mem_req  out  1  memory read request
- mem_addr  out  DATA_WIDTH  memory read address
- mem_rdata  in  DATA_WIDTH  memory read data; valid when mem_ready=1
- mem_ready  in  1  memory read completion
- pc_load  out  1  PC register load strobe
- pc_out  out  DATA_WIDTH  new PC value
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse; constant 0 without the optional feature

Behaviour:
- Reset is asynchronous and active-high; one clock domain.
- While rst=1: state=IDLE; all outputs and internal registers are 0.
- States: IDLE, SAVE, MEM, LOAD, plus ERR with the optional feature. Outputs are Moore outputs decoded from state and the internal registers.
- IDLE:
  - start=1 latches vec = {0, trap_addr_in[VEC_WIDTH-1:0]} and ret_pc = pc_in, then goes to SAVE.
  - trap_addr_in bits above VEC_WIDTH are ignored; the block re-zero-extends the vector.
- SAVE (exactly 1 cycle):
  - reg_wr_en=1, reg_wr_addr=LINK_REG, reg_wr_data=ret_pc.
  - Always goes to MEM.
- MEM:
  - mem_req=1 and mem_addr=vec, held stable until mem_ready=1 is sampled.
  - On the mem_ready=1 edge: capture mem_rdata into tgt and go to LOAD.
  - mem_ready=0: stay in MEM.
- LOAD (exactly 1 cycle):
  - pc_load=1, pc_out=tgt, done=1.
  - Always returns to IDLE.
- Outside their asserting states: reg_wr_en, mem_req, pc_load, done and err are 0. reg_wr_addr, reg_wr_data, mem_addr and pc_out keep their last values (0 after reset).
- start while busy=1 is ignored and not queued.
- mem_ready sampled in any state other than MEM is ignored.
- Minimum latency with mem_ready high in the first MEM cycle:
  - start sampled at edge 0.
  - SAVE in cycle 1, MEM in cycle 2, LOAD (pc_load, done) in cycle 3.
  - IDLE in cycle 4; start is accepted again at that edge.
- Reset mid-operation: immediate abort. No pc_load or done is produced. A register write already issued is not undone.
- Back-to-back traps: start high in the cycle after LOAD (state IDLE) is accepted.

Optional Feature:
- Macro: TRAP_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to MEM and increments each cycle in MEM with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES, go to ERR instead of waiting.
  - ERR lasts 1 cycle: err=1, no pc_load, no done, then IDLE.
  - mem_ready=1 in the same cycle the limit is reached wins: normal LOAD path.
- Undefined: no counter is built, MEM waits indefinitely, and err is tied to 0.

Test Plan:
- Reset: assert rst mid-idle and mid-MEM -> all outputs 0 immediately, state IDLE, no pc_load afterwards.
- Basic trap: trap_addr_in=0x0025, pc_in=0x3001, mem_ready high on first MEM cycle, mem_rdata=0x0490 -> cycle 1: reg write R7=0x3001; cycle 2: mem_req with mem_addr=0x0025; cycle 3: pc_load with pc_out=0x0490 and done=1.
- Wait states and masking: trap_addr_in=0xFF23, mem_ready delayed 3 cycles -> mem_addr=0x0023 held for 4 cycles, then pc_load in the following cycle.
- Busy protection: pulse start again during MEM with a different vector -> ignored; a single done; R7 written once.
- Back-to-back: start in the cycle after done with trap_addr_in=0x0021 -> second sequence completes normally with mem_addr=0x0021.
- Timeout (TRAP_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=4): mem_ready held at 0 -> err pulses one cycle after 4 MEM cycles; no pc_load; busy returns to 0.
